// File: rtl/instruction_prefetch_queue_pkg.sv
// prefetch_info: state encoding and word-address helper shared by the prefetch queue
package prefetch_info;
  typedef enum logic {PQ_IDLE, PQ_STREAM} pq_state_t;
  localparam int WORD_BYTES = 4;
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return (addr & ~32'h3) + 32'(WORD_BYTES);
  endfunction
endpackage

// File: rtl/instruction_prefetch_queue_fifo.sv
// prefetch_fifo: DEPTH-entry circular word buffer with push/pop/flush; flush wins over push
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/instruction_prefetch_queue.sv
// instruction_prefetch_queue: sequential instruction prefetcher; define PREFETCH_STATS_EN for saturating hit/miss/drop counters
module instruction_prefetch_queue import prefetch_info::*; #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_drops
`endif
);
  pq_state_t state, state_nx;
  logic [CNT_W-1:0] count, inflight, drop;
  logic [31:0] fetch_addr, head_addr, head_word, cpu_word;
  logic stream, match, hit, pending, redirect, ack, resp, discard, push;
  assign cpu_word = cpu_addr & ~32'h3;
  assign stream = state == PQ_STREAM;
  assign match = cpu_word == head_addr;
  assign hit = cpu_read && stream && count != '0 && match;
  // An empty queue at the head address means the word is in flight or about to be requested.
  assign pending = cpu_read && stream && count == '0 && match;
  assign redirect = cpu_read && !hit && !pending;
  assign cpu_busy = cpu_read && !hit;
  assign cpu_rdata = hit ? head_word : '0;
  assign mem_req = stream && !redirect && (count + inflight) < CNT_W'(DEPTH);
  assign mem_addr = fetch_addr;
  assign ack = mem_req && mem_ack;
  assign resp = mem_rvalid && (drop != '0 || inflight != '0);
  assign discard = resp && (drop != '0 || redirect);
  assign push = resp && !discard;
  always_comb state_nx = redirect ? PQ_STREAM : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= PQ_IDLE;
      inflight   <= '0;
      drop       <= '0;
      fetch_addr <= '0;
      head_addr  <= '0;
    end else begin
      state <= state_nx;
      if (redirect) begin
        inflight   <= '0;
        drop       <= drop + inflight - CNT_W'(resp);
        fetch_addr <= cpu_word;
        head_addr  <= cpu_word;
      end else begin
        inflight <= inflight + CNT_W'(ack) - CNT_W'(push);
        drop     <= drop - CNT_W'(discard);
        if (ack) fetch_addr <= next_word_addr(fetch_addr);
        if (hit) head_addr <= next_word_addr(head_addr);
      end
    end
  prefetch_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(hit),
    .flush(redirect),
    .wr_data(mem_rdata),
    .rd_data(head_word),
    .count(count)
  );
`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_drops  <= '0;
    end else begin
      stat_hits   <= stat_hits + 32'(hit && stat_hits != '1);
      stat_misses <= stat_misses + 32'(redirect && stat_misses != '1);
      stat_drops  <= stat_drops + 32'(discard && stat_drops != '1);
    end
`endif
endmodule
